// File: rtl/counter_ctrl_unit_pkg.sv
// Shared types and helpers for the counter control stage: debounce state
// encoding and a constant-width helper for counter sizing.
package counter_ctrl_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WAIT_PRESS   = 3'd1,
    ST_PRESSED      = 3'd2,
    ST_HELD         = 3'd3,
    ST_WAIT_RELEASE = 3'd4
  } db_state_e;

  // Bits needed to hold 0..v-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (((v - 1) >> i) != 0) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/counter_ctrl_unit_btn_debounce.sv
// Push-button conditioner: multi-stage synchronizer followed by a press/release
// debounce FSM that emits one pulse per accepted press.
module btn_debounce
  import counter_ctrl_unit_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_pulse
);

  localparam int unsigned CW = clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  db_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   btn_s;

  assign btn_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], btn_raw};
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d = ST_WAIT_PRESS;
          cnt_d   = '0;
        end
      end
      ST_WAIT_PRESS: begin
        if (!btn_s)                state_d = ST_IDLE;
        else if (cnt_q == CNT_LAST) state_d = ST_PRESSED;
        else                       cnt_d   = cnt_q + CW'(1);
      end
      ST_PRESSED: state_d = ST_HELD;
      ST_HELD: begin
        if (!btn_s) begin
          state_d = ST_WAIT_RELEASE;
          cnt_d   = '0;
        end
      end
      ST_WAIT_RELEASE: begin
        if (btn_s)                 state_d = ST_HELD;
        else if (cnt_q == CNT_LAST) state_d = ST_IDLE;
        else                       cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pure state decode: one cycle wide, no path from btn_raw.
  assign press_pulse = (state_q == ST_PRESSED);

endmodule

// File: rtl/counter_ctrl_unit.sv
// Control stage for the 4-bit counter: prescaled count-enable tick, button
// driven direction toggle and clear strobe, all as registered outputs.
module counter_ctrl_unit
  import counter_ctrl_unit_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned DB_CYCLES   = 500_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_dir,
  input  logic btn_clr,
  input  logic sw_run,
  output logic cnt_en,
  output logic cnt_up,
  output logic cnt_clr
);

  localparam int unsigned PW = clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic                   dir_pulse, clr_pulse, run_s;
  logic [SYNC_STAGES-1:0] run_sync_q, run_sync_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic                   en_q, en_d, up_q, up_d, clr_q, clr_d;

  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db_dir (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_dir),
    .press_pulse (dir_pulse)
  );

  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_clr),
    .press_pulse (clr_pulse)
  );

  assign run_s = run_sync_q[SYNC_STAGES-1];

  // Clear outranks the tick; a paused prescaler holds its value.
  always_comb begin
    run_sync_d = {run_sync_q[SYNC_STAGES-2:0], sw_run};
    presc_d    = presc_q;
    en_d       = 1'b0;
    clr_d      = 1'b0;
    up_d       = dir_pulse ? ~up_q : up_q;
    if (clr_pulse) begin
      clr_d   = 1'b1;
      presc_d = '0;
    end else if (run_s) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        en_d    = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_sync_q <= '0;
      presc_q    <= '0;
      en_q       <= 1'b0;
      up_q       <= 1'b1;
      clr_q      <= 1'b0;
    end else begin
      run_sync_q <= run_sync_d;
      presc_q    <= presc_d;
      en_q       <= en_d;
      up_q       <= up_d;
      clr_q      <= clr_d;
    end
  end

  assign cnt_en  = en_q;
  assign cnt_up  = up_q;
  assign cnt_clr = clr_q;

endmodule

// File: tb/tb_counter_ctrl_unit.sv
// Directed bench for counter_ctrl_unit with TICK_DIV=4, DB_CYCLES=3, SYNC_STAGES=2.
module tb_counter_ctrl_unit;

  logic clk = 1'b0;
  logic rst, btn_dir, btn_clr, sw_run;
  logic cnt_en, cnt_up, cnt_clr;
  int   n_checks = 0;
  int   n_fail   = 0;

  counter_ctrl_unit #(.TICK_DIV(4), .DB_CYCLES(3), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_dir (btn_dir),
    .btn_clr (btn_clr),
    .sw_run  (sw_run),
    .cnt_en  (cnt_en),
    .cnt_up  (cnt_up),
    .cnt_clr (cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one posedge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Step until a cnt_en tick is seen (the prescaler is then 0), bounded.
  task automatic wait_en(input string tag);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cnt_en) break;
    end
    check_eq(tag, cnt_en, 1'b1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; btn_dir = 1'b0; btn_clr = 1'b0; sw_run = 1'b1;
    ticks(2);
    check_eq("rst_up", cnt_up, 1'b1);
    check_eq("rst_en", cnt_en, 1'b0);
    check_eq("rst_clr", cnt_clr, 1'b0);
    rst = 1'b0;

    // 1: run sync lands after edge 2, first wrap at edge 6, then every 4.
    for (int k = 1; k <= 14; k++) begin
      tick();
      check_eq("t1_en", cnt_en, (k == 6) || (k == 10) || (k == 14));
      check_eq("t1_clr", cnt_clr, 1'b0);
    end
    check_eq("t1_up", cnt_up, 1'b1);

    // 2: press toggles cnt_up at the 7th edge after raw rises; no repeat.
    btn_dir = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_eq("t2_toggle", cnt_up, (k < 7));
    end
    ticks(13);
    check_eq("t2_held", cnt_up, 1'b0);
    btn_dir = 1'b0;
    ticks(10);
    check_eq("t2_release", cnt_up, 1'b0);
    btn_dir = 1'b1;
    ticks(6);
    check_eq("t2_second_pre", cnt_up, 1'b0);
    tick();
    check_eq("t2_second", cnt_up, 1'b1);
    ticks(13);
    btn_dir = 1'b0;
    ticks(10);

    // 3: single-cycle bounce never passes debounce.
    btn_dir = 1'b1; tick();
    btn_dir = 1'b0; tick();
    btn_dir = 1'b1; tick();
    btn_dir = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      check_eq("t3_bounce", cnt_up, 1'b1);
    end

    // 4: clear pulse lands on the wrap edge e0+8; tick dropped, next at e0+12.
    wait_en("t4_sync");
    tick();
    btn_clr = 1'b1;
    for (int j = 2; j <= 12; j++) begin
      tick();
      check_eq("t4_clr", cnt_clr, (j == 8));
      check_eq("t4_en", cnt_en, (j == 4) || (j == 12));
      if (j == 9) btn_clr = 1'b0;
    end
    ticks(10);
    check_eq("t4_clr_quiet", cnt_clr, 1'b0);

    // 5: pause takes hold with prescaler at 2; resume wraps 2 edges after sync.
    wait_en("t5_sync");
    sw_run = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      check_eq("t5_paused", cnt_en, 1'b0);
    end
    sw_run = 1'b1;
    for (int j = 11; j <= 14; j++) begin
      tick();
      check_eq("t5_resume", cnt_en, (j == 14));
    end

    // 6: reset in WAIT_PRESS restores cnt_up and leaves no stray pulse.
    btn_dir = 1'b1;
    ticks(7);
    check_eq("t6_down", cnt_up, 1'b0);
    btn_dir = 1'b0;
    ticks(10);
    btn_dir = 1'b1;
    ticks(4);
    rst = 1'b1;
    btn_dir = 1'b0;
    tick();
    check_eq("t6_rst_up", cnt_up, 1'b1);
    check_eq("t6_rst_en", cnt_en, 1'b0);
    check_eq("t6_rst_clr", cnt_clr, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_eq("t6_no_late", cnt_up, 1'b1);
      check_eq("t6_en", cnt_en, (k == 6) || (k == 10));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
